adapter_from_bus_q: RTL

Parametrised successor to the fixed 32-to-128 bus-to-message adapter. Collects BUS_W-bit beats delimited by `last` into one MSG_W-bit message with a beat count, then queues completed messages in a DEPTH-entry FIFO. Over-long messages are truncated, flagged and counted instead of corrupting the next message. Sits between a user-side write bus and a request port.

---
 rtl/adapter_from_bus_q_if.sv | 27 ++
 rtl/adapter_from_bus_q.sv | 117 +++++++++++
 2 files changed

// File: rtl/adapter_from_bus_q_if.sv
// Write-bus beat port and assembled-message request port of the bus-to-message adapter.

interface adapter_from_bus_q_in_if #(
  parameter int unsigned BUS_W = 32
);
  logic             enq__ENA;
  logic [BUS_W-1:0] enq_v;
  logic             enq_last;
  logic             enq__RDY;

  modport master (output enq__ENA, enq_v, enq_last, input enq__RDY);
  modport slave  (input enq__ENA, enq_v, enq_last, output enq__RDY);
endinterface

interface adapter_from_bus_q_out_if #(
  parameter int unsigned MSG_W = 128,
  parameter int unsigned LEN_W = 16
);
  logic             enq__ENA;
  logic [MSG_W-1:0] enq_v;
  logic [LEN_W-1:0] enq_length;
  logic             enq_trunc;
  logic             enq__RDY;

  modport master (output enq__ENA, enq_v, enq_length, enq_trunc, input enq__RDY);
  modport slave  (input enq__ENA, enq_v, enq_length, enq_trunc, output enq__RDY);
endinterface

// File: rtl/adapter_from_bus_q.sv
// Assembles BUS_W-bit beats into MSG_W-bit messages (truncating over-long ones)
// and queues completed messages in a DEPTH-entry FIFO.

module adapter_from_bus_q #(
  parameter int unsigned BUS_W = 32,
  parameter int unsigned MSG_W = 128,
  parameter int unsigned LEN_W = 16,
  parameter int unsigned DEPTH = 2
) (
  input  logic                     CLK,
  input  logic                     nRST,
  adapter_from_bus_q_in_if.slave   in,
  adapter_from_bus_q_out_if.master out,
  output logic [15:0]              ovf_count
);

  localparam int unsigned MAXB  = MSG_W / BUS_W;
  localparam int unsigned IDX_W = $clog2(MAXB + 1);
  localparam int unsigned PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int unsigned CNT_W = $clog2(DEPTH + 1);

  typedef struct packed {
    logic [MSG_W-1:0] v;
    logic [LEN_W-1:0] length;
    logic             trunc;
  } entry_t;

  logic [MSG_W-1:0] asm_q;
  logic [IDX_W-1:0] idx_q;
  logic [LEN_W-1:0] len_q;
  logic             trunc_q;
  entry_t           mem [DEPTH];
  logic [PTR_W-1:0] wr_ptr_q;
  logic [PTR_W-1:0] rd_ptr_q;
  logic [CNT_W-1:0] cnt_q;
  logic             rdy_q;
  logic             ena_q;
  logic [15:0]      ovf_q;

  logic [MSG_W-1:0] asm_c;
  logic [LEN_W-1:0] len_c;
  logic             trunc_c;
  logic             accept_c;
  logic             push_c;
  logic             pop_c;
  logic [CNT_W-1:0] cnt_c;

  function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
    return (p == PTR_W'(DEPTH - 1)) ? '0 : p + PTR_W'(1);
  endfunction

  // Merge the incoming beat into the buffer; beats past MAXB only mark truncation.
  always_comb begin
    asm_c = asm_q;
    for (int b = 0; b < int'(MAXB); b++) begin
      if (idx_q == IDX_W'(b)) asm_c[b*BUS_W +: BUS_W] = in.enq_v;
    end
    len_c    = (&len_q) ? len_q : len_q + LEN_W'(1);
    trunc_c  = trunc_q | (idx_q == IDX_W'(MAXB));
    accept_c = in.enq__ENA & rdy_q;
    push_c   = accept_c & in.enq_last;
    pop_c    = ena_q & out.enq__RDY;
    cnt_c    = cnt_q + CNT_W'(push_c) - CNT_W'(pop_c);
  end

  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      asm_q    <= '0;
      idx_q    <= '0;
      len_q    <= '0;
      trunc_q  <= 1'b0;
      for (int i = 0; i < int'(DEPTH); i++) mem[i] <= '0;
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      cnt_q    <= '0;
      rdy_q    <= 1'b0;
      ena_q    <= 1'b0;
      ovf_q    <= '0;
    end else begin
      if (accept_c) begin
        if (in.enq_last) begin
          asm_q   <= '0;
          idx_q   <= '0;
          len_q   <= '0;
          trunc_q <= 1'b0;
        end else begin
          asm_q   <= asm_c;
          idx_q   <= (idx_q == IDX_W'(MAXB)) ? idx_q : idx_q + IDX_W'(1);
          len_q   <= len_c;
          trunc_q <= trunc_c;
        end
      end
      if (push_c) begin
        mem[wr_ptr_q] <= '{v: asm_c, length: len_c, trunc: trunc_c};
        wr_ptr_q      <= ptr_inc(wr_ptr_q);
        if (trunc_c && ovf_q != 16'hFFFF) ovf_q <= ovf_q + 16'd1;
      end
      if (pop_c) rd_ptr_q <= ptr_inc(rd_ptr_q);
      cnt_q <= cnt_c;
      // Back-pressure and valid derive from the next occupancy, so both stay registered.
      rdy_q <= (cnt_c < CNT_W'(DEPTH));
      ena_q <= (cnt_c != '0);
    end
  end

  assign in.enq__RDY     = rdy_q;
  assign out.enq__ENA    = ena_q;
  assign out.enq_v       = mem[rd_ptr_q].v;
  assign out.enq_length  = mem[rd_ptr_q].length;
  assign out.enq_trunc   = mem[rd_ptr_q].trunc;
  assign ovf_count       = ovf_q;

  // Caller must only offer beats while the adapter is ready.
  assert property (@(posedge CLK) disable iff (!nRST) in.enq__ENA |-> rdy_q)
    else $error("adapter_from_bus_q: in enq ENA asserted while RDY low");

endmodule
